ctrl_pipe_sequencer: RTL

Carries decode-stage control bits through the Execute, Memory and Writeback pipeline registers. Holds the architectural NZCV flags register and evaluates ARM condition codes in the Execute stage. Gates register writes, memory writes, PC writes and branches with the condition result. Sits between control_unit (Decode stage) and the datapath/hazard logic.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/ctrl_pipe_sequencer_cond_check.sv | 43 ++++
 rtl/ctrl_pipe_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: ARM condition-code encodings and NZCV flag bit positions.
`timescale 1ns/1ps
package cpu_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/ctrl_pipe_sequencer_cond_check.sv
// Combinational ARM condition evaluation of the Execute-stage cond field
// against the architectural NZCV flags.
`timescale 1ns/1ps
module cond_check
  import cpu_pkg::*;
#(
  parameter logic UNDEF_NEVER = 1'b1
) (
  input  logic [3:0] CondE,
  input  logic [3:0] FlagsQ,
  output logic       CondExE
);

  logic n, z, c, v;

  assign n = FlagsQ[FLAG_N];
  assign z = FlagsQ[FLAG_Z];
  assign c = FlagsQ[FLAG_C];
  assign v = FlagsQ[FLAG_V];

  always_comb begin
    CondExE = 1'b0;
    case (CondE)
      COND_EQ: CondExE = z;
      COND_NE: CondExE = !z;
      COND_CS: CondExE = c;
      COND_CC: CondExE = !c;
      COND_MI: CondExE = n;
      COND_PL: CondExE = !n;
      COND_VS: CondExE = v;
      COND_VC: CondExE = !v;
      COND_HI: CondExE = c & !z;
      COND_LS: CondExE = !c | z;
      COND_GE: CondExE = (n == v);
      COND_LT: CondExE = (n != v);
      COND_GT: CondExE = !z & (n == v);
      COND_LE: CondExE = z | (n != v);
      COND_AL: CondExE = 1'b1;
      default: CondExE = !UNDEF_NEVER;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_sequencer.sv
// Carries decoded control through the E/M/W registers, owns the NZCV flags
// register and gates architectural side effects with the Execute condition.
`timescale 1ns/1ps
module ctrl_pipe_sequencer
  import cpu_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000,
  parameter logic       UNDEF_NEVER = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] CondD,
  input  logic       PCSrcD,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       MemWriteD,
  input  logic [1:0] ALUControlD,
  input  logic       BranchD,
  input  logic       ALUSrcD,
  input  logic [1:0] FlagWriteD,
  input  logic       FlushE,
  input  logic [3:0] ALUFlagsE,
  output logic [1:0] ALUControlE,
  output logic       ALUSrcE,
  output logic       MemtoRegE,
  output logic       BranchTakenE,
  output logic       CondExE,
  output logic [3:0] FlagsQ,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       MemtoRegM,
  output logic       PCSrcM,
  output logic       RegWriteW,
  output logic       MemtoRegW,
  output logic       PCSrcW
);

  logic [3:0] cond_p0;
  logic       pc_src_p0, reg_write_p0, mem_to_reg_p0, mem_write_p0;
  logic [1:0] alu_control_p0;
  logic       branch_p0, alu_src_p0;
  logic [1:0] flag_write_p0;

  logic       reg_write_p1, mem_write_p1, mem_to_reg_p1, pc_src_p1;
  logic       reg_write_p2, mem_to_reg_p2, pc_src_p2;
  logic [3:0] flags_q;

  // Execute stage: decoded control, or an all-zero bubble on flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cond_p0        <= 4'b0000;
      pc_src_p0      <= 1'b0;
      reg_write_p0   <= 1'b0;
      mem_to_reg_p0  <= 1'b0;
      mem_write_p0   <= 1'b0;
      alu_control_p0 <= 2'b00;
      branch_p0      <= 1'b0;
      alu_src_p0     <= 1'b0;
      flag_write_p0  <= 2'b00;
    end else if (FlushE) begin
      cond_p0        <= 4'b0000;
      pc_src_p0      <= 1'b0;
      reg_write_p0   <= 1'b0;
      mem_to_reg_p0  <= 1'b0;
      mem_write_p0   <= 1'b0;
      alu_control_p0 <= 2'b00;
      branch_p0      <= 1'b0;
      alu_src_p0     <= 1'b0;
      flag_write_p0  <= 2'b00;
    end else begin
      cond_p0        <= CondD;
      pc_src_p0      <= PCSrcD;
      reg_write_p0   <= RegWriteD;
      mem_to_reg_p0  <= MemtoRegD;
      mem_write_p0   <= MemWriteD;
      alu_control_p0 <= ALUControlD;
      branch_p0      <= BranchD;
      alu_src_p0     <= ALUSrcD;
      flag_write_p0  <= FlagWriteD;
    end
  end

  cond_check #(
    .UNDEF_NEVER(UNDEF_NEVER)
  ) u_cond_check (
    .CondE  (cond_p0),
    .FlagsQ (flags_q),
    .CondExE(CondExE)
  );

  // Flags commit at the end of Execute; each half is independently enabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= FLAGS_RESET;
    end else begin
      if (flag_write_p0[1] && CondExE) begin
        flags_q[FLAG_N] <= ALUFlagsE[FLAG_N];
        flags_q[FLAG_Z] <= ALUFlagsE[FLAG_Z];
      end
      if (flag_write_p0[0] && CondExE) begin
        flags_q[FLAG_C] <= ALUFlagsE[FLAG_C];
        flags_q[FLAG_V] <= ALUFlagsE[FLAG_V];
      end
    end
  end

  // Memory stage: side effects already gated by the Execute condition
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_p1  <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      pc_src_p1     <= 1'b0;
    end else begin
      reg_write_p1  <= reg_write_p0 & CondExE;
      mem_write_p1  <= mem_write_p0 & CondExE;
      mem_to_reg_p1 <= mem_to_reg_p0;
      pc_src_p1     <= pc_src_p0 & CondExE;
    end
  end

  // Writeback stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_p2  <= 1'b0;
      mem_to_reg_p2 <= 1'b0;
      pc_src_p2     <= 1'b0;
    end else begin
      reg_write_p2  <= reg_write_p1;
      mem_to_reg_p2 <= mem_to_reg_p1;
      pc_src_p2     <= pc_src_p1;
    end
  end

  assign ALUControlE  = alu_control_p0;
  assign ALUSrcE      = alu_src_p0;
  assign MemtoRegE    = mem_to_reg_p0;
  assign BranchTakenE = branch_p0 & CondExE;
  assign FlagsQ       = flags_q;
  assign RegWriteM    = reg_write_p1;
  assign MemWriteM    = mem_write_p1;
  assign MemtoRegM    = mem_to_reg_p1;
  assign PCSrcM       = pc_src_p1;
  assign RegWriteW    = reg_write_p2;
  assign MemtoRegW    = mem_to_reg_p2;
  assign PCSrcW       = pc_src_p2;

endmodule
